// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake for uart_tx_buffered: the writer offers data_tx/valid,
// and the transmitter answers with tx_ready while its FIFO has room.
interface uart_tx_buffered_if #(
    parameter int unsigned BITS_N = 8
);
    logic [BITS_N-1:0] data_tx;
    logic              valid;
    logic              tx_ready;

    modport master (output data_tx, output valid, input tx_ready);
    modport slave  (input data_tx, input valid, output tx_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: queued words are sent LSB-first with optional
// parity and 1-2 stop bits, back-to-back with no idle gap between frames.
module uart_tx_buffered #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned BITS_N       = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_buffered_if.slave             wr,
    output logic                          uart_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(BITS_N);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam bit          PAR_EN = (PARITY == 1) || (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t              state, state_next;
    logic [BITS_N-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_next;
    logic [BITS_N-1:0]   word;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic                stop_idx;
    logic                tx_ready;
    logic                push, pop, baud_end, par_bit;

    assign wr.tx_ready = tx_ready;
    assign fifo_count  = count;
    assign push        = wr.valid && tx_ready;
    assign baud_end    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: if (count != '0) begin
                pop        = 1'b1;
                state_next = S_START;
            end
            S_START: if (baud_end) state_next = S_DATA;
            S_DATA: if (baud_end && bit_idx == BIT_W'(BITS_N - 1))
                state_next = PAR_EN ? S_PARITY : S_STOP;
            S_PARITY: if (baud_end) state_next = S_STOP;
            S_STOP: if (baud_end && stop_idx == 1'(STOP_BITS - 1)) begin
                // Chain straight into the next start bit when more words wait.
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = S_START;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        par_bit = (PARITY == 1) ? ~(^word) : (^word);
        case (state)
            S_START:  uart_out = 1'b0;
            S_DATA:   uart_out = word[bit_idx];
            S_PARITY: uart_out = par_bit;
            default:  uart_out = 1'b1;
        endcase
    end

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (!push && pop) count_next = count - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            word     <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr.data_tx;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                word   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            tx_ready <= (count_next != CNT_W'(FIFO_DEPTH));
            busy     <= (state_next != S_IDLE) || (count_next != '0);

            if (state == S_IDLE || state_next != state || baud_end) baud_cnt <= '0;
            else                                                    baud_cnt <= baud_cnt + 1'b1;

            if (state != S_DATA) bit_idx <= '0;
            else if (baud_end)   bit_idx <= (bit_idx == BIT_W'(BITS_N - 1)) ? '0 : bit_idx + 1'b1;

            if (state != S_STOP) stop_idx <= 1'b0;
            else if (baud_end)   stop_idx <= (stop_idx == 1'(STOP_BITS - 1)) ? 1'b0 : ~stop_idx;
        end
    end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised successor to the single-word UART transmitter. It accepts words through a valid/ready handshake into an internal FIFO and serialises them LSB-first at a fixed baud divisor. Frame format is configurable: data width, parity mode and stop-bit count. Consecutive FIFO entries are sent back-to-back with no idle gap. It sits between the camera/control logic and the board's UART TX pin.

## Interface
- CLKS_PER_BIT, 434: clock cycles per serial bit (50 MHz / 115200); must be ≥2.
- BITS_N, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- data_tx  in  BITS_N  word to enqueue.
- valid  in  1  data_tx is valid; write accepted on an edge where valid && tx_ready.
- tx_ready  out  1  FIFO not full.
- uart_out  out  1  serial line, idle high.
- busy  out  1  frame in progress, or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words currently queued (excludes the word being shifted).

## Operation
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH; count is a separate register.
- Push on valid && tx_ready; valid while full is ignored, and data is dropped without corruption.
- Push and pop on the same edge: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: uart_out=1; if count>0, pop the head into the shift register and go to START.
  - START: uart_out=0 for CLKS_PER_BIT cycles.
  - DATA: shift out BITS_N bits LSB-first, each held CLKS_PER_BIT cycles.
  - PARITY: entered only when PARITY≠0. Bit = XOR of data bits for even mode, inverted for odd mode, so the total ones count (data + parity) is even or odd respectively.
  - STOP: uart_out=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - On the last STOP cycle, if count>0, pop and go directly to START; otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state/bit change. Width is $clog2(CLKS_PER_BIT).
- Bit index counter: counts 0..BITS_N-1 within DATA; stop-bit counter counts 0..STOP_BITS-1.
- Frame length: (1 + BITS_N + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, exactly.
- Parity is computed from the latched word, not from data_tx.
- Illegal PARITY values (3) behave as 0.

## Timing
- Reset values: uart_out=1, tx_ready=1, busy=0, fifo_count=0, FSM=IDLE, pointers=0. These take effect asynchronously on reset assertion, including mid-frame. The FIFO is flushed and no partial frame resumes.
- tx_ready, busy and fifo_count are registered and reflect state after the current edge.
- Latency, empty FIFO in IDLE:
  - Write accepted at edge k → fifo_count=1 after edge k.
  - Pop at edge k+1 → fifo_count=0, uart_out=0 from edge k+1.
- busy rises after edge k. It falls after the edge ending the last stop bit, when the FIFO is empty.
- Back-to-back frames: start bit of frame n+1 follows the last stop cycle of frame n with zero gap.
- Full FIFO: tx_ready=0 after the edge making count=FIFO_DEPTH. tx_ready returns to 1 after the edge of the next pop.
- Throughput ceiling: one word per frame length. Writer may fill all FIFO_DEPTH entries while a frame shifts, giving FIFO_DEPTH+1 words in flight.

## Test plan
- Defaults, reset released, send 0x61 once → uart_out after pop is 0, then 1,0,0,0,0,1,1,0, then 1. Each level lasts exactly 434 cycles; busy low 4340 cycles after pop.
- PARITY=2, send 0x61 (three ones) → parity bit 1. PARITY=1, same word → parity bit 0. Frame length 11×434 cycles.
- STOP_BITS=2, BITS_N=7, send 0x64 → 7 data bits 0,0,1,0,0,1,1, then 868 cycles high. Total 10×434 cycles.
- FIFO_DEPTH=4, push 6 words 0x61..0x66 on consecutive cycles:
  - First word popped, next 4 queued, tx_ready=0, 6th write (0x66) dropped.
  - Line shows 0x61..0x65 back-to-back with no idle cycles; fifo_count steps 4→3→2→1→0.
- Push on the same edge as an internal pop (count=2, write during last stop cycle) → fifo_count stays 2, and the word order on the line is preserved.
- Assert reset in the middle of DATA bit 3 → uart_out=1 immediately (before next edge), fifo_count=0, tx_ready=1. After release, a new word 0x63 is sent cleanly with a correct frame.
